// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle sequencer for the RV32M multiply/divide ops.
// It runs a shift-add multiplier or a restoring divider at one bit per cycle.
// It holds busy high until it pulses done with the registered result.
// Optional build macro: MULDIV_ZERO_SKIP_EN. When it is defined, a multiply with
// a zero operand returns 0 through the one-cycle special-case path.
module muldiv_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] a_q;      // multiplicand or divisor magnitude
    logic [XLEN-1:0] hi_q;     // product upper half or partial remainder
    logic [XLEN-1:0] lo_q;     // multiplier / product lower half, or quotient
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic            is_div;
    logic            sgn1;
    logic            sgn2;
    logic            s1;
    logic            s2;
    logic            neg_new;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            special;
    logic [XLEN-1:0] special_res;

    // Decode the incoming request: operand magnitudes, result sign, short-cut cases.
    always_comb begin
        is_div      = funct3[2];
        sgn1        = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) ||
                      (funct3 == 3'd6);
        sgn2        = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        s1          = sgn1 & op1[XLEN-1];
        s2          = sgn2 & op2[XLEN-1];
        mag1        = s1 ? -op1 : op1;
        mag2        = s2 ? -op2 : op2;
        // The remainder takes the dividend's sign. Every other result takes s1^s2.
        neg_new     = (is_div && funct3[1]) ? s1 : (s1 ^ s2);
        special     = 1'b0;
        special_res = '0;
        if (is_div && (op2 == '0)) begin
            special     = 1'b1;
            special_res = funct3[1] ? op1 : '1;
        end else if (is_div && !funct3[0] && (op1 == MinNeg) && (op2 == '1)) begin
            special     = 1'b1;
            special_res = funct3[1] ? '0 : MinNeg;
        end
`ifdef MULDIV_ZERO_SKIP_EN
        else if (!is_div && ((op1 == '0) || (op2 == '0))) begin
            special     = 1'b1;
            special_res = '0;
        end
`endif
    end

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    logic [XLEN-1:0] hi_step;
    logic [XLEN-1:0] lo_step;

    // One iteration step of the multiplier or the restoring divider.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : {XLEN{1'b0}})};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, a_q};
        // The difference is below the divisor when used, so XLEN bits are enough.
        div_diff  = div_shift[XLEN-1:0] - a_q;
        if (op_q[2]) begin
            hi_step = div_ge ? div_diff : div_shift[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    // Sign correction and selection of the output word.
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -lo_q : lo_q;
        rem_fix  = neg_q ? -hi_q : hi_q;
        case (op_q)
            3'd0:                fix_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fix_res = quo_fix;
            default:             fix_res = rem_fix;
        endcase
    end

    // Sequencer: accept a request, iterate, correct the sign, then pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q  <= funct3;
                        neg_q <= neg_new;
                        cnt_q <= CntW'(XLEN);
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            a_q     <= is_div ? mag2 : mag1;
                            hi_q    <= '0;
                            lo_q    <= is_div ? mag1 : mag2;
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    hi_q  <= hi_step;
                    lo_q  <= lo_step;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    result_q <= fix_res;
                    done_q   <= 1'b1;
                    state_q  <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // The stall goes high in the accept cycle itself so that the issuing instruction holds.
    always_comb begin
        busy = ((state_q == StIdle) && start) || (state_q == StCalc) || (state_q == StFix);
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl. The driver pushes the expected result and
// done cycle for each request. A monitor pops and compares on every done pulse.
module tb_muldiv_ctrl;

    localparam int XLEN = 32;
    localparam int LatFull = XLEN + 2;
`ifdef MULDIV_ZERO_SKIP_EN
    localparam int LatZero = 1;
`else
    localparam int LatZero = XLEN + 2;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    muldiv_ctrl #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op1    (op1),
        .op2    (op2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0] res;
        int              due;
        string           name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [XLEN-1:0] last_exp = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, 64'(result), 64'(e.res));
                check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    // Issue one request, scramble the inputs afterwards, and count the cycles with busy high.
    task automatic do_op(input string name, input logic [2:0] f, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] want,
                         input int lat);
        exp_t e;
        int   bc;
        @(posedge clk); #1;
        e.res  = want;
        e.due  = cyc + lat;
        e.name = name;
        sb.push_back(e);
        last_exp = want;
        start  = 1'b1;
        funct3 = f;
        op1    = a;
        op2    = b;
        bc     = 0;
        @(negedge clk);
        if (busy) bc++;
        @(posedge clk); #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        op1    = $urandom;
        op2    = $urandom;
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
            sb.delete();
        end
        check({name, "_busy_cycles"}, 64'(bc), 64'(lat));
    endtask

    // Count done pulses over n cycles while none are expected.
    task automatic watch_no_done(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check({name, "_no_done"}, 64'(seen), 64'd0);
    endtask

    int c0;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = '0;
        op1    = '0;
        op2    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {31'd0, busy, done, result}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op("mul_7x6",        3'd0, 32'd7,        32'd6,        32'h0000_002A, LatFull);
        do_op("mulh_m1x2",      3'd1, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, LatFull);
        do_op("mulhu_ffx2",     3'd3, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, LatFull);
        do_op("mulhsu_m1x2",    3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, LatFull);
        do_op("mulh_min_sq",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LatFull);
        do_op("mul_ff_sq",      3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LatFull);
        do_op("mulhu_ff_sq",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LatFull);
        do_op("div_m7_2",       3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, LatFull);
        do_op("rem_m7_2",       3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, LatFull);
        do_op("remu_7_2",       3'd7, 32'd7,        32'd2,        32'h0000_0001, LatFull);
        do_op("divu_ff_16",     3'd5, 32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF, LatFull);
        do_op("remu_ff_16",     3'd7, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, LatFull);
        do_op("div_min_2",      3'd4, 32'h8000_0000, 32'd2,        32'hC000_0000, LatFull);
        do_op("divu_by_zero",   3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        do_op("rem_by_zero",    3'd6, 32'd13,       32'd0,        32'h0000_000D, 1);
        do_op("rem_overflow",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        do_op("div_overflow",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

        // Flush at cycle 10 of a DIV: busy low from cycle 11, no done, result held.
        @(posedge clk); #1;
        c0     = cyc;
        start  = 1'b1;
        funct3 = 3'd4;
        op1    = 32'd100;
        op2    = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < c0 + 10) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_low", 64'(busy), 64'd0);
        check("flush_result_held", 64'(result), 64'(last_exp));
        watch_no_done("flush", 40);
        do_op("divu_100_3", 3'd5, 32'd100, 32'd3, 32'd33, LatFull);

        // Flush together with start in IDLE: the start is dropped.
        @(posedge clk); #1;
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'd0;
        op1    = 32'd3;
        op2    = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_start_busy", 64'(busy), 64'd0);
        watch_no_done("flush_start", 40);
        check("flush_start_result", 64'(result), 64'(last_exp));

        // Reset mid-CALC: all outputs clear on the next cycle and the op is lost.
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = 3'd0;
        op1    = 32'd7;
        op2    = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midcalc_reset", {31'd0, busy, done, result}, 64'd0);
        watch_no_done("midcalc_reset", 40);

        do_op("mul_0x5", 3'd0, 32'd0, 32'd5, 32'd0, LatZero);
        do_op("mulhu_5x0", 3'd3, 32'd5, 32'd0, 32'd0, LatZero);
        do_op("mul_3x5", 3'd0, 32'd3, 32'd5, 32'd15, LatFull);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
